// File: rtl/dcache_arb_pkg.sv
// Shared types and helpers for the dcache arbiters: chosen-index width,
// default write-request layout and arbitration mode encodings.
package dcache_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int DEF_WAY_W  = 1;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_MASK_W = 1;
  localparam int DEF_DATA_W = 64;

  typedef struct packed {
    logic [DEF_WAY_W-1:0]  way_en;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_MASK_W-1:0] wmask;
    logic [DEF_DATA_W-1:0] data;
  } wreq_t;

  function automatic int chosen_width(int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dcache_data_write_arbiter_if.sv
// Requester/SRAM-side bundle for the data-array write arbiter.
// Optional io_stall_cnt exists only with DCACHE_DATA_WARB_STALL_CNT_EN.
interface dcache_data_write_arbiter_if #(
  parameter int N_IN   = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64,
  parameter int WAY_W  = 1,
  parameter int MASK_W = 1,
  parameter int CHW    = 2
);
  logic [N_IN-1:0]        io_in_valid;
  logic [N_IN-1:0]        io_in_ready;
  logic [N_IN*WAY_W-1:0]  io_in_way_en;
  logic [N_IN*ADDR_W-1:0] io_in_addr;
  logic [N_IN*MASK_W-1:0] io_in_wmask;
  logic [N_IN*DATA_W-1:0] io_in_data;
  logic                   io_out_ready;
  logic                   io_out_valid;
  logic [WAY_W-1:0]       io_out_way_en;
  logic [ADDR_W-1:0]      io_out_addr;
  logic [MASK_W-1:0]      io_out_wmask;
  logic [DATA_W-1:0]      io_out_data;
  logic [CHW-1:0]         io_out_chosen;
`ifdef DCACHE_DATA_WARB_STALL_CNT_EN
  logic [31:0]            io_stall_cnt;

  modport master (
    output io_in_valid, io_in_way_en, io_in_addr, io_in_wmask, io_in_data, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_way_en, io_out_addr, io_out_wmask,
           io_out_data, io_out_chosen, io_stall_cnt
  );
  modport slave (
    input  io_in_valid, io_in_way_en, io_in_addr, io_in_wmask, io_in_data, io_out_ready,
    output io_in_ready, io_out_valid, io_out_way_en, io_out_addr, io_out_wmask,
           io_out_data, io_out_chosen, io_stall_cnt
  );
`else
  modport master (
    output io_in_valid, io_in_way_en, io_in_addr, io_in_wmask, io_in_data, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_way_en, io_out_addr, io_out_wmask,
           io_out_data, io_out_chosen
  );
  modport slave (
    input  io_in_valid, io_in_way_en, io_in_addr, io_in_wmask, io_in_data, io_out_ready,
    output io_in_ready, io_out_valid, io_out_way_en, io_out_addr, io_out_wmask,
           io_out_data, io_out_chosen
  );
`endif
endinterface

// File: rtl/arb_rr_select.sv
// Combinational winner select: fixed priority (index 0 first) or
// round-robin search starting at ptr and wrapping modulo N.
module arb_rr_select
  import dcache_arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int CHW = chosen_width(N)
) (
  input  logic [N-1:0]   valid,
  input  logic [CHW-1:0] ptr,
  input  logic           mode,
  output logic [N-1:0]   grant,
  output logic [CHW-1:0] idx,
  output logic           any_valid
);
  int base;
  int j;

  // Scan from lowest priority up so the highest-priority hit is written last.
  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = |valid;
    base      = (mode == MODE_RR) ? int'(ptr) : 0;
    j         = 0;
    for (int off = N - 1; off >= 0; off--) begin
      j = (base + off) % N;
      if (valid[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = CHW'(j);
      end
    end
  end
endmodule

// File: rtl/dcache_data_write_arbiter.sv
// N-way data-array write arbiter with a one-entry registered output stage.
// Optional stall counter enabled by DCACHE_DATA_WARB_STALL_CNT_EN.
module dcache_data_write_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 64,
  parameter int WAY_W   = 1,
  parameter int MASK_W  = 1,
  parameter int RR_MODE = 1
) (
  input logic clock,
  input logic reset,
  dcache_data_write_arbiter_if.slave io
);
  localparam int CHW = chosen_width(N_IN);

  typedef struct packed {
    logic [WAY_W-1:0]  way_en;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] data;
  } req_t;

  logic            out_valid_q, out_valid_d;
  req_t            req_q, req_d;
  logic [CHW-1:0]  chosen_q, chosen_d;
  logic [CHW-1:0]  ptr_q, ptr_d;
  logic [N_IN-1:0] grant;
  logic [CHW-1:0]  win_idx;
  logic            any_valid;
  logic            load;
  req_t            win_req;

  arb_rr_select #(.N(N_IN)) u_sel (
    .valid     (io.io_in_valid),
    .ptr       (ptr_q),
    .mode      ((RR_MODE != 0) ? MODE_RR : MODE_FIXED),
    .grant     (grant),
    .idx       (win_idx),
    .any_valid (any_valid)
  );

  assign load = !out_valid_q || io.io_out_ready;

  // Reset gates ready so nothing handshakes while the stage is being cleared.
  assign io.io_in_ready = (load && any_valid && !reset) ? grant : '0;

  always_comb begin
    win_req.way_en = io.io_in_way_en[win_idx*WAY_W +: WAY_W];
    win_req.addr   = io.io_in_addr[win_idx*ADDR_W +: ADDR_W];
    win_req.wmask  = io.io_in_wmask[win_idx*MASK_W +: MASK_W];
    win_req.data   = io.io_in_data[win_idx*DATA_W +: DATA_W];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    req_d       = req_q;
    chosen_d    = chosen_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = any_valid;
      if (any_valid) begin
        req_d    = win_req;
        chosen_d = win_idx;
        if (RR_MODE != 0)
          ptr_d = (win_idx == CHW'(N_IN - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      req_q       <= '0;
      chosen_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      req_q       <= req_d;
      chosen_q    <= chosen_d;
      ptr_q       <= ptr_d;
    end
  end

  assign io.io_out_valid  = out_valid_q;
  assign io.io_out_way_en = req_q.way_en;
  assign io.io_out_addr   = req_q.addr;
  assign io.io_out_wmask  = req_q.wmask;
  assign io.io_out_data   = req_q.data;
  assign io.io_out_chosen = chosen_q;

`ifdef DCACHE_DATA_WARB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !io.io_out_ready && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign io.io_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_dcache_data_write_arbiter.sv
// Bench: fixed-priority and round-robin instances driven with identical
// stimulus, each checked against its own model and output scoreboard.
module tb_dcache_data_write_arbiter;
  localparam int N = 4;

  typedef struct packed {
    logic [1:0]  chosen;
    logic [0:0]  way;
    logic [11:0] addr;
    logic [0:0]  mask;
    logic [63:0] data;
  } entry_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [N-1:0]       in_valid = '0;
  logic [N-1:0][0:0]  in_way   = '0;
  logic [N-1:0][11:0] in_addr  = '0;
  logic [N-1:0][0:0]  in_mask  = '0;
  logic [N-1:0][63:0] in_data  = '0;
  logic               out_ready = 1'b0;

  dcache_data_write_arbiter_if #(.N_IN(N), .CHW(2)) ifx ();
  dcache_data_write_arbiter_if #(.N_IN(N), .CHW(2)) ifr ();

  assign ifx.io_in_valid  = in_valid;  assign ifr.io_in_valid  = in_valid;
  assign ifx.io_in_way_en = in_way;    assign ifr.io_in_way_en = in_way;
  assign ifx.io_in_addr   = in_addr;   assign ifr.io_in_addr   = in_addr;
  assign ifx.io_in_wmask  = in_mask;   assign ifr.io_in_wmask  = in_mask;
  assign ifx.io_in_data   = in_data;   assign ifr.io_in_data   = in_data;
  assign ifx.io_out_ready = out_ready; assign ifr.io_out_ready = out_ready;

  dcache_data_write_arbiter #(.N_IN(N), .RR_MODE(0)) u_fx (.clock(clock), .reset(reset), .io(ifx));
  dcache_data_write_arbiter #(.N_IN(N), .RR_MODE(1)) u_rr (.clock(clock), .reset(reset), .io(ifr));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Reference model state, index 0 = fixed, 1 = round-robin
  logic        mv[2];
  int          mptr[2];
  int unsigned mstall[2];
  entry_t      q0[$];
  entry_t      q1[$];

  function automatic int win(logic [N-1:0] v, int p, bit rr);
    for (int off = 0; off < N; off++) begin
      int j;
      j = ((rr ? p : 0) + off) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; mptr[m] = 0; mstall[m] = 0;
    end
    q0.delete(); q1.delete();
  endtask

  task automatic check_mode(input int m);
    logic          g_val;
    logic [N-1:0]  g_rdy, e_rdy;
    logic [1:0]    g_ch;
    logic [11:0]   g_addr;
    logic [63:0]   g_data;
    logic [0:0]    g_way, g_mask;
    logic [31:0]   g_stall;
    string         p;
    entry_t        e, ne;
    logic          load;
    int            w;
    p = (m == 0) ? "fx_" : "rr_";
    if (m == 0) begin
      g_val = ifx.io_out_valid; g_rdy = ifx.io_in_ready; g_ch = ifx.io_out_chosen;
      g_addr = ifx.io_out_addr; g_data = ifx.io_out_data; g_way = ifx.io_out_way_en;
      g_mask = ifx.io_out_wmask;
    end else begin
      g_val = ifr.io_out_valid; g_rdy = ifr.io_in_ready; g_ch = ifr.io_out_chosen;
      g_addr = ifr.io_out_addr; g_data = ifr.io_out_data; g_way = ifr.io_out_way_en;
      g_mask = ifr.io_out_wmask;
    end
`ifdef DCACHE_DATA_WARB_STALL_CNT_EN
    g_stall = (m == 0) ? ifx.io_stall_cnt : ifr.io_stall_cnt;
    chk({p, "stall"}, 64'(g_stall), 64'(mstall[m]));
`else
    g_stall = '0;
`endif
    load  = !mv[m] || out_ready;
    w     = win(in_valid, mptr[m], m == 1);
    e_rdy = (load && w >= 0) ? N'(1 << w) : '0;
    chk({p, "ready"}, 64'(g_rdy), 64'(e_rdy));
    chk({p, "out_valid"}, 64'(g_val), 64'(mv[m]));
    if (mv[m]) begin
      e = (m == 0) ? q0[0] : q1[0];
      chk({p, "chosen"}, 64'(g_ch), 64'(e.chosen));
      chk({p, "addr"}, 64'(g_addr), 64'(e.addr));
      chk({p, "data"}, g_data, e.data);
      chk({p, "way"}, 64'(g_way), 64'(e.way));
      chk({p, "mask"}, 64'(g_mask), 64'(e.mask));
    end
    // Advance model to the state after the coming clock edge
    if (mv[m] && !out_ready && mstall[m] != 32'hFFFF_FFFF) mstall[m]++;
    if (mv[m] && out_ready) begin
      if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (load) begin
      mv[m] = (w >= 0);
      if (w >= 0) begin
        ne = '{chosen: 2'(w), way: in_way[w], addr: in_addr[w], mask: in_mask[w], data: in_data[w]};
        if (m == 0) q0.push_back(ne); else q1.push_back(ne);
        if (m == 1) mptr[m] = (w + 1) % N;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic r, input bit rnd);
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        in_way[i]  = 1'($urandom);
        in_mask[i] = 1'($urandom);
        in_addr[i] = 12'($urandom);
        in_data[i] = {$urandom, $urandom};
      end
    end
    in_valid  = v;
    out_ready = r;
    #1;
    check_mode(0);
    check_mode(1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    model_clear();
    // Reset and idle
    repeat (2) @(posedge clock);
    #1;
    chk("rst_fx_valid", 64'(ifx.io_out_valid), 64'd0);
    chk("rst_rr_valid", 64'(ifr.io_out_valid), 64'd0);
    chk("rst_fx_chosen", 64'(ifx.io_out_chosen), 64'd0);
    chk("rst_rr_ready", 64'(ifr.io_in_ready), 64'd0);
    reset = 1'b0;
    step(4'b0000, 1'b1, 1'b1);

    // Fixed priority on 1110 grants 1; rr from ptr 0 also grants 1
    step(4'b1110, 1'b1, 1'b1);
    chk("fx_grant1_chosen", 64'(ifx.io_out_chosen), 64'd1);
    chk("fx_grant1_addr", 64'(ifx.io_out_addr), 64'(q0[0].addr));
    step(4'b0000, 1'b1, 1'b1);

    // Backpressure with requester 2 holding addr 0A5
    in_addr[2] = 12'h0A5;
    step(4'b0100, 1'b1, 1'b0);
    chk("bp_rr_addr", 64'(ifr.io_out_addr), 64'h0A5);
    chk("bp_rr_chosen", 64'(ifr.io_out_chosen), 64'd2);
    repeat (3) step(4'b1111, 1'b0, 1'b1);
    chk("bp_rr_addr_hold", 64'(ifr.io_out_addr), 64'h0A5);
`ifdef DCACHE_DATA_WARB_STALL_CNT_EN
    chk("bp_stall3", 64'(ifr.io_stall_cnt), 64'd3);
`endif

    // Dequeue and enqueue in the same cycle
    in_data[2] = 64'hDEAD_BEEF;
    step(4'b0100, 1'b1, 1'b0);
    chk("deq_enq_data", ifr.io_out_data, 64'hDEAD_BEEF);
    chk("deq_enq_valid", 64'(ifr.io_out_valid), 64'd1);

    // Random traffic and backpressure
    for (int k = 0; k < 40; k++) step(4'($urandom), 1'($urandom), 1'b1);

    // Reset mid-transfer clears output within the same cycle
    step(4'b1111, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_fx_valid", 64'(ifx.io_out_valid), 64'd0);
    chk("midrst_rr_valid", 64'(ifr.io_out_valid), 64'd0);
    chk("midrst_rr_ready", 64'(ifr.io_in_ready), 64'd0);
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Round-robin with all requesters valid: 0,1,2,3,0,1 then settle
    for (int k = 0; k < 6; k++) begin
      step(4'b1111, 1'b1, 1'b1);
      chk("rr_seq", 64'(ifr.io_out_chosen), 64'(k % N));
    end
    step(4'b0000, 1'b1, 1'b1);

    // Wrap: grant 0 (ptr->1), then 1001 grants 3 (ptr->0), then 0
    step(4'b0001, 1'b1, 1'b1);
    step(4'b1001, 1'b1, 1'b1);
    chk("rr_wrap3", 64'(ifr.io_out_chosen), 64'd3);
    step(4'b1001, 1'b1, 1'b1);
    chk("rr_wrap0", 64'(ifr.io_out_chosen), 64'd0);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dcache_data_write_arbiter.md
Name: dcache_data_write_arbiter

Overview:
- N-way arbiter for data-array write requests (way_en, addr, wmask, data) feeding the dcache data SRAM write port.
- Generalises the existing 2-input fixed-priority combinational arbiter:
  - parametrised requester count and field widths
  - selectable fixed-priority or round-robin mode
  - registered output stage (1-entry pipeline register) to cut the timing path to the SRAM
- Sits between the write requesters (store pipe, refill, ECC scrub) and the data array.

Parameters:
N_IN, 4, number of requesters (2..8)
ADDR_W, 12, address width
DATA_W, 64, data width
WAY_W, 1, way_en width
MASK_W, 1, wmask width
RR_MODE, 1, 1 = round-robin; 0 = fixed priority (index 0 highest)

Ports:
clock  in  1  clock
reset  in  1  asynchronous active-high reset
io_in_valid  in  N_IN  per-requester valid
io_in_ready  out  N_IN  per-requester ready
io_in_way_en  in  N_IN*WAY_W  flattened, requester i at [i*WAY_W +: WAY_W]
io_in_addr  in  N_IN*ADDR_W  flattened addresses
io_in_wmask  in  N_IN*MASK_W  flattened write masks
io_in_data  in  N_IN*DATA_W  flattened write data
io_out_ready  in  1  SRAM write port can accept
io_out_valid  out  1  registered request valid
io_out_way_en  out  WAY_W  registered way enable
io_out_addr  out  ADDR_W  registered address
io_out_wmask  out  MASK_W  registered mask
io_out_data  out  DATA_W  registered data
io_out_chosen  out  CHW  index of the granted requester; CHW = max(1, clog2(N_IN))

Behaviour:
- Reset (asynchronous, active-high): io_out_valid=0, all io_out_* bits=0, io_out_chosen=0, RR pointer=0.
- Arbitration (combinational, same cycle):
  - Winner is the highest-priority valid requester.
  - Fixed mode: lowest index wins.
  - RR mode: search starts at ptr and wraps modulo N_IN.
- Stage enable: load = !io_out_valid || io_out_ready.
- Ready:
  - io_in_ready[i] = load && (i == winner) && any_valid.
  - Exactly one ready is asserted, or none.
  - Ready never depends on io_in_valid[i] of losers.
- On the clock edge when load=1:
  - out_valid <= any_valid.
  - If any_valid: bits and chosen <= winner's fields.
  - If !any_valid: bits hold their previous values (don't-care while invalid).
- Latency: request accepted in cycle t appears on io_out_* in cycle t+1.
- Full throughput: 1 request per cycle when io_out_ready is held high.
- Backpressure: while io_out_valid && !io_out_ready:
  - all io_in_ready = 0
  - io_out_* and io_out_chosen stay stable
  - ptr holds
- RR pointer:
  - Updates only on an accepted handshake (io_in_valid[k] && io_in_ready[k]): ptr <= (k+1) mod N_IN.
  - Wrap: k = N_IN-1 gives ptr = 0.
  - In fixed mode, ptr is unused and stays 0.
- Simultaneous dequeue and enqueue (out_valid && out_ready && any_valid): new entry replaces old with no bubble.
- Single requester held valid continuously: wins every cycle in both modes.
- Requesters may drop valid before being granted; no lock is held.
- Reset asserted mid-transfer: pending output is discarded immediately; no handshake completes that cycle.

Optional Feature:
- Macro: DCACHE_DATA_WARB_STALL_CNT_EN.
- When defined:
  - Adds output io_stall_cnt (32 bits).
  - Increments each cycle where io_out_valid && !io_out_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Async reset to 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package dcache_arb_pkg holds:
  - function chosen_width(n) returning max(1, clog2(n))
  - packed struct type for a write request {way_en, addr, wmask, data}, parametrised through localparam widths
  - RR/fixed mode constants
- One sub-module: arb_rr_select.
  - Purely combinational.
  - Inputs: valid vector, ptr, mode.
  - Outputs: one-hot grant, encoded index, any_valid.
  - Reused by other dcache arbiters.
- The top level holds the pipeline register, the ptr register and the optional counter.

Test Plan:
1. Reset, then idle -> io_out_valid=0, io_out_chosen=0, all io_in_ready=0. Assert reset mid-transfer -> io_out_valid=0 in the same cycle.
2. Fixed priority (RR_MODE=0), N_IN=4, valid=4'b1110, out_ready=1 -> grant to 1; next cycle io_out_chosen=1 and io_out_addr equals requester 1's addr.
3. RR mode, all 4 valid continuously, out_ready=1 -> io_out_chosen sequence 0,1,2,3,0,1 with no bubble cycles.
4. RR mode, valid=4'b1001, ptr=1 -> requester 3 granted; ptr becomes 0 (wrap); next grant goes to 0.
5. Backpressure: out_valid=1 holding addr 12'h0A5 and chosen=2, out_ready=0 for 3 cycles, new requests present -> outputs stable, all ready=0, ptr unchanged. With DCACHE_DATA_WARB_STALL_CNT_EN defined, io_stall_cnt=3.
6. Simultaneous dequeue/enqueue: out_valid=1, out_ready=1, requester 2 valid with data 64'hDEAD_BEEF -> next cycle io_out_data=64'hDEAD_BEEF, io_out_valid stays 1.
